br_tag_mgr: RTL and testbench
=============================

Name: br_tag_mgr

Overview:
- Parametrised branch-tag manager for the R10K dispatch stage; successor to the single-branch mask controller.
- Allocates up to DISP_W branch tags per cycle, in order, lowest free tag first.
- Keeps a per-tag checkpoint of the dependency mask, so a mispredict needs only the one-hot tag of the wrong branch to restore state and squash younger tags.
- Broadcasts clear/squash masks to ROB, RS and the map-table/free-list stacks.

Parameters:
- BR_MASK_W, 5, number of branch tags (mask width).
- DISP_W, 2, branch dispatch slots per cycle.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- br_req_i  in  DISP_W  per-slot request; slot 0 is oldest; caller has already filtered non-saving branches.
- br_state_i  in  `BR_STATE_W  resolve status: `BR_PR_NONE / `BR_PR_CORRECT / `BR_PR_WRONG.
- br_rslv_tag_i  in  BR_MASK_W  one-hot tag of the resolving branch.
- br_gnt_o  out  DISP_W  per-slot grant.
- br_tag_o  out  DISP_W*BR_MASK_W  per-slot one-hot allocated tag; 0 if not granted.
- br_dep_mask_o  out  DISP_W*BR_MASK_W  per-slot dependency mask for the instruction in that slot.
- br_mask_o  out  BR_MASK_W  registered live-tag mask.
- br_clr_bit_o  out  BR_MASK_W  one-hot tag cleared by a CORRECT resolve; combinational, same cycle.
- br_squash_mask_o  out  BR_MASK_W  tags killed by a WRONG resolve; combinational, same cycle.
- free_cnt_o  out  $clog2(BR_MASK_W+1)  number of free tags (registered).
- full_o  out  1  all tags in use.
- rslv_err_o  out  1  sticky flag: a resolve named a tag that is not live.

Behaviour:
- State: mask[BR_MASK_W], snap[BR_MASK_W][BR_MASK_W], err. On rst, asynchronously: mask=0, all snap=0, err=0. So br_mask_o=0, free_cnt_o=BR_MASK_W, full_o=0, rslv_err_o=0.
- Reset asserted mid-operation discards all tags immediately. Outputs stay at reset values while rst=1.
- Valid resolve: br_state_i≠NONE and br_rslv_tag_i is one-hot and a subset of mask. Any other non-NONE resolve is ignored and sets err on the next edge.
- CORRECT resolve:
  - br_clr_bit_o = tag.
  - next mask clears that bit.
  - Every snap entry clears that bit.
  - The freed tag is not reallocatable until the next cycle.
- WRONG resolve:
  - br_squash_mask_o = mask & ~snap[tag]. This includes the wrong tag itself.
  - next mask = snap[tag].
  - All br_req_i are ignored that cycle, so br_gnt_o = 0.
  - Squashed tags' snap entries are don't-care; they are rewritten on reallocation.
- Allocation (no WRONG resolve this cycle):
  - base = mask & ~br_clr_bit_o.
  - Grants are in-order prefix only: slot i is granted iff br_req_i[i], every requesting slot j<i is granted, and a free tag remains.
  - A non-requesting slot does not block later slots, and consumes no tag.
  - Free tags are assigned lowest index first, in ascending slot order.
- Per-slot dependency mask: br_dep_mask_o[i] = base | tags granted to slots j<i. Ungranted slots output base plus all earlier grants.
- On each grant, snap[tag] <= that slot's dep mask, and next mask sets the tag bit.
- Simultaneous CORRECT resolve and allocation in one cycle is legal. The cleared bit is excluded from the dep masks and snapshots written that cycle.
- Outputs: gnt/tag/dep/clr/squash are combinational from registered state plus inputs. free_cnt_o and full_o derive from the registered mask. No latency beyond one edge to update state.
- full_o=1 means no grants are possible this cycle (a same-cycle clear does not help).

Decomposition:
- Shared package/header: BR_STATE_W, `BR_PR_NONE/`BR_PR_CORRECT/`BR_PR_WRONG encodings, default BR_MASK_W, DISP_W.
- Add a one-hot tag typedef and a helper function for one-hot validity.
- One natural sub-module: br_prio_alloc, a combinational multi-grant lowest-free-bit picker (free vector, request vector -> DISP_W one-hot grants). Reused by the free list.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with mask=5'b01011 -> br_mask_o=0, free_cnt_o=5, all outputs 0 before the next edge.
- Dual dispatch from empty, req=2'b11 -> tags 5'b00001 and 5'b00010; dep masks 0 and 5'b00001; next mask 5'b00011.
- Partial grant with mask=5'b10111, req=2'b11 -> gnt=2'b01, tag0=5'b01000; next cycle full_o=1, free_cnt_o=0.
- CORRECT resolve plus dispatch with mask=5'b00111, resolve tag 5'b00010, req=2'b01 -> clr=5'b00010, granted tag 5'b01000, dep=5'b00101; next mask 5'b01101; snap of 5'b00100 no longer contains bit 1.
- Nested WRONG: allocate A,B,C one per cycle (tags 1,2,4), then WRONG on B -> squash=5'b00110, gnt=0 despite req; next mask 5'b00001.
- Error: CORRECT on tag 5'b10000 with mask=5'b00001 -> mask unchanged, clr=0, rslv_err_o=1 and stays sticky until rst.

Source files
------------

// File: rtl/br_tag_mgr_pkg.sv
// Shared definitions for the branch-tag manager: resolve-status encodings,
// default sizing, the one-hot tag type and a one-hot validity helper.
package br_tag_mgr_pkg;

  localparam int BR_STATE_W = 2;

  localparam logic [BR_STATE_W-1:0] BR_PR_NONE    = 2'd0;
  localparam logic [BR_STATE_W-1:0] BR_PR_CORRECT = 2'd1;
  localparam logic [BR_STATE_W-1:0] BR_PR_WRONG   = 2'd2;

  localparam int BR_MASK_W_DEF = 5;
  localparam int DISP_W_DEF    = 2;

  // One-hot branch tag at the default mask width.
  typedef logic [BR_MASK_W_DEF-1:0] br_tag_t;

  // Exactly one bit set; callers zero-extend narrower vectors.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/br_prio_alloc.sv
// Combinational multi-grant picker: hands out the lowest free bits to requesting
// slots in slot order; a denied requester blocks every later slot.
module br_prio_alloc #(
  parameter int W = 5,
  parameter int N = 2
) (
  input  logic [W-1:0]   free_vec,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [N*W-1:0] tag
);

  logic [W-1:0] avail;
  logic [W-1:0] pick;
  logic         blocked;

  always_comb begin
    avail   = free_vec;
    pick    = '0;
    blocked = 1'b0;
    gnt     = '0;
    tag     = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !blocked) begin
        if (avail != '0) begin
          // Isolate the lowest set bit of the remaining free vector.
          pick            = avail & (~avail + W'(1));
          gnt[i]          = 1'b1;
          tag[i*W +: W]   = pick;
          avail           = avail & ~pick;
        end else begin
          blocked = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/br_tag_mgr.sv
// Branch-tag manager: in-order multi-slot tag allocation with per-tag mask
// checkpoints so a mispredict restores the live mask from one snapshot.
module br_tag_mgr
  import br_tag_mgr_pkg::*;
#(
  parameter int BR_MASK_W = BR_MASK_W_DEF,
  parameter int DISP_W    = DISP_W_DEF,
  localparam int CNT_W    = $clog2(BR_MASK_W + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DISP_W-1:0]           br_req_i,
  input  logic [BR_STATE_W-1:0]       br_state_i,
  input  logic [BR_MASK_W-1:0]        br_rslv_tag_i,
  output logic [DISP_W-1:0]           br_gnt_o,
  output logic [DISP_W*BR_MASK_W-1:0] br_tag_o,
  output logic [DISP_W*BR_MASK_W-1:0] br_dep_mask_o,
  output logic [BR_MASK_W-1:0]        br_mask_o,
  output logic [BR_MASK_W-1:0]        br_clr_bit_o,
  output logic [BR_MASK_W-1:0]        br_squash_mask_o,
  output logic [CNT_W-1:0]            free_cnt_o,
  output logic                        full_o,
  output logic                        rslv_err_o
);

  logic [BR_MASK_W-1:0] mask_q;
  logic [BR_MASK_W-1:0] mask_nxt;
  logic [BR_MASK_W-1:0] snap_q   [BR_MASK_W];
  logic [BR_MASK_W-1:0] snap_nxt [BR_MASK_W];
  logic                 err_q;

  logic                 rslv_active;
  logic                 rslv_valid;
  logic                 rslv_correct;
  logic                 rslv_wrong;
  logic [BR_MASK_W-1:0] snap_sel;
  logic [BR_MASK_W-1:0] base;
  logic [BR_MASK_W-1:0] granted_all;
  logic [DISP_W-1:0]    req_eff;
  logic [DISP_W-1:0]    gnt;
  logic [DISP_W*BR_MASK_W-1:0] alloc_tag;
  logic [DISP_W*BR_MASK_W-1:0] dep;
  logic [CNT_W-1:0]     cnt;

  // A resolve is honoured only for a known status naming exactly one live tag.
  assign rslv_active  = (br_state_i != BR_PR_NONE);
  assign rslv_valid   = ((br_state_i == BR_PR_CORRECT) || (br_state_i == BR_PR_WRONG))
                        && is_onehot(32'(br_rslv_tag_i))
                        && ((br_rslv_tag_i & ~mask_q) == '0);
  assign rslv_correct = rslv_valid && (br_state_i == BR_PR_CORRECT);
  assign rslv_wrong   = rslv_valid && (br_state_i == BR_PR_WRONG);

  always_comb begin
    snap_sel = '0;
    for (int k = 0; k < BR_MASK_W; k++) begin
      if (br_rslv_tag_i[k]) snap_sel = snap_sel | snap_q[k];
    end
  end

  assign br_clr_bit_o     = rslv_correct ? br_rslv_tag_i : '0;
  assign br_squash_mask_o = rslv_wrong ? (mask_q & ~snap_sel) : '0;
  assign base             = mask_q & ~br_clr_bit_o;
  assign req_eff          = rslv_wrong ? '0 : br_req_i;

  // Free vector uses the registered mask: a tag cleared this cycle stays busy.
  br_prio_alloc #(
    .W (BR_MASK_W),
    .N (DISP_W)
  ) u_alloc (
    .free_vec (~mask_q),
    .req      (req_eff),
    .gnt      (gnt),
    .tag      (alloc_tag)
  );

  always_comb begin
    dep         = '0;
    granted_all = '0;
    for (int i = 0; i < DISP_W; i++) begin
      dep[i*BR_MASK_W +: BR_MASK_W] = base | granted_all;
      granted_all = granted_all | alloc_tag[i*BR_MASK_W +: BR_MASK_W];
    end
  end

  always_comb begin
    mask_nxt = rslv_wrong ? snap_sel : (base | granted_all);
    for (int k = 0; k < BR_MASK_W; k++) begin
      snap_nxt[k] = snap_q[k] & ~br_clr_bit_o;
    end
    for (int i = 0; i < DISP_W; i++) begin
      for (int k = 0; k < BR_MASK_W; k++) begin
        if (alloc_tag[i*BR_MASK_W + k]) snap_nxt[k] = dep[i*BR_MASK_W +: BR_MASK_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      err_q  <= 1'b0;
      for (int k = 0; k < BR_MASK_W; k++) snap_q[k] <= '0;
    end else begin
      mask_q <= mask_nxt;
      err_q  <= err_q | (rslv_active & ~rslv_valid);
      for (int k = 0; k < BR_MASK_W; k++) snap_q[k] <= snap_nxt[k];
    end
  end

  always_comb begin
    cnt = '0;
    for (int k = 0; k < BR_MASK_W; k++) begin
      if (!mask_q[k]) cnt = cnt + CNT_W'(1);
    end
  end

  assign br_gnt_o      = gnt;
  assign br_tag_o      = alloc_tag;
  assign br_dep_mask_o = dep;
  assign br_mask_o     = mask_q;
  assign free_cnt_o    = cnt;
  assign full_o        = &mask_q;
  assign rslv_err_o    = err_q;

endmodule

// File: tb/tb_br_tag_mgr.sv
// Directed bench for br_tag_mgr: allocation, resolve, mispredict, error and
// asynchronous reset scenarios with hand-computed expectations.
module tb_br_tag_mgr;
  import br_tag_mgr_pkg::*;

  localparam int MW = 5;
  localparam int DW = 2;
  localparam int CW = $clog2(MW + 1);

  logic              clk;
  logic              rst;
  logic [DW-1:0]     br_req_i;
  logic [1:0]        br_state_i;
  logic [MW-1:0]     br_rslv_tag_i;
  logic [DW-1:0]     br_gnt_o;
  logic [DW*MW-1:0]  br_tag_o;
  logic [DW*MW-1:0]  br_dep_mask_o;
  logic [MW-1:0]     br_mask_o;
  logic [MW-1:0]     br_clr_bit_o;
  logic [MW-1:0]     br_squash_mask_o;
  logic [CW-1:0]     free_cnt_o;
  logic              full_o;
  logic              rslv_err_o;

  int total = 0;
  int bad   = 0;

  br_tag_mgr #(.BR_MASK_W(MW), .DISP_W(DW)) dut (
    .clk              (clk),
    .rst              (rst),
    .br_req_i         (br_req_i),
    .br_state_i       (br_state_i),
    .br_rslv_tag_i    (br_rslv_tag_i),
    .br_gnt_o         (br_gnt_o),
    .br_tag_o         (br_tag_o),
    .br_dep_mask_o    (br_dep_mask_o),
    .br_mask_o        (br_mask_o),
    .br_clr_bit_o     (br_clr_bit_o),
    .br_squash_mask_o (br_squash_mask_o),
    .free_cnt_o       (free_cnt_o),
    .full_o           (full_o),
    .rslv_err_o       (rslv_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Drive inputs just after a rising edge, then let combinational outputs settle.
  task automatic drive(input logic [DW-1:0] req, input logic [1:0] st, input logic [MW-1:0] tg);
    br_req_i      = req;
    br_state_i    = st;
    br_rslv_tag_i = tg;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive('0, BR_PR_NONE, '0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  initial begin
    rst = 1'b1;
    br_req_i = '0;
    br_state_i = BR_PR_NONE;
    br_rslv_tag_i = '0;
    #1;
    check("rst_mask", 32'(br_mask_o), 32'h0);
    check("rst_free", 32'(free_cnt_o), 32'd5);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_err",  32'(rslv_err_o), 32'd0);
    #2;
    rst = 1'b0;
    step();

    // Dual dispatch from empty.
    drive(2'b11, BR_PR_NONE, '0);
    check("dual_gnt",  32'(br_gnt_o), 32'b11);
    check("dual_tag0", 32'(br_tag_o[4:0]), 32'b00001);
    check("dual_tag1", 32'(br_tag_o[9:5]), 32'b00010);
    check("dual_dep0", 32'(br_dep_mask_o[4:0]), 32'b00000);
    check("dual_dep1", 32'(br_dep_mask_o[9:5]), 32'b00001);
    step();
    check("dual_mask", 32'(br_mask_o), 32'b00011);
    check("dual_free", 32'(free_cnt_o), 32'd3);

    // Single dispatch, then CORRECT resolve of tag 1 alongside a dispatch.
    drive(2'b01, BR_PR_NONE, '0);
    check("one_tag0", 32'(br_tag_o[4:0]), 32'b00100);
    step();
    drive(2'b01, BR_PR_CORRECT, 5'b00010);
    check("cor_clr",  32'(br_clr_bit_o), 32'b00010);
    check("cor_gnt",  32'(br_gnt_o), 32'b01);
    check("cor_tag0", 32'(br_tag_o[4:0]), 32'b01000);
    check("cor_dep0", 32'(br_dep_mask_o[4:0]), 32'b00101);
    check("cor_sq",   32'(br_squash_mask_o), 32'b0);
    step();
    check("cor_mask", 32'(br_mask_o), 32'b01101);

    // WRONG on tag 2: its snapshot must have lost bit 1.
    drive(2'b11, BR_PR_WRONG, 5'b00100);
    check("wsnap_sq",  32'(br_squash_mask_o), 32'b01100);
    check("wsnap_gnt", 32'(br_gnt_o), 32'b00);
    check("wsnap_tag", 32'(br_tag_o), 32'b0);
    step();
    check("wsnap_mask", 32'(br_mask_o), 32'b00001);

    // Nested WRONG: A, B, C one per cycle, then mispredict B.
    do_reset();
    drive(2'b01, BR_PR_NONE, '0);
    check("nest_a", 32'(br_tag_o[4:0]), 32'b00001);
    step();
    drive(2'b01, BR_PR_NONE, '0);
    check("nest_b", 32'(br_tag_o[4:0]), 32'b00010);
    step();
    drive(2'b01, BR_PR_NONE, '0);
    check("nest_c", 32'(br_tag_o[4:0]), 32'b00100);
    step();
    drive(2'b11, BR_PR_WRONG, 5'b00010);
    check("nest_sq",  32'(br_squash_mask_o), 32'b00110);
    check("nest_gnt", 32'(br_gnt_o), 32'b00);
    check("nest_clr", 32'(br_clr_bit_o), 32'b0);
    step();
    check("nest_mask", 32'(br_mask_o), 32'b00001);

    // Fill all tags, clear one (no same-cycle reuse), then a partial grant.
    do_reset();
    drive(2'b11, BR_PR_NONE, '0); step();
    drive(2'b01, BR_PR_NONE, '0); step();
    drive(2'b11, BR_PR_NONE, '0); step();
    check("fill_full", 32'(full_o), 32'd1);
    drive(2'b11, BR_PR_CORRECT, 5'b01000);
    check("fill_gnt", 32'(br_gnt_o), 32'b00);
    check("fill_clr", 32'(br_clr_bit_o), 32'b01000);
    step();
    check("fill_mask", 32'(br_mask_o), 32'b10111);
    drive(2'b11, BR_PR_NONE, '0);
    check("part_gnt",  32'(br_gnt_o), 32'b01);
    check("part_tag0", 32'(br_tag_o[4:0]), 32'b01000);
    check("part_tag1", 32'(br_tag_o[9:5]), 32'b00000);
    check("part_dep0", 32'(br_dep_mask_o[4:0]), 32'b10111);
    check("part_dep1", 32'(br_dep_mask_o[9:5]), 32'b11111);
    step();
    check("part_full", 32'(full_o), 32'd1);
    check("part_free", 32'(free_cnt_o), 32'd0);

    // Resolve of a non-live tag: ignored, sticky error.
    do_reset();
    drive(2'b01, BR_PR_NONE, '0); step();
    drive(2'b00, BR_PR_CORRECT, 5'b10000);
    check("err_clr", 32'(br_clr_bit_o), 32'b0);
    step();
    check("err_mask", 32'(br_mask_o), 32'b00001);
    check("err_flag", 32'(rslv_err_o), 32'd1);
    drive(2'b11, BR_PR_NONE, '0); step();
    check("err_stky", 32'(rslv_err_o), 32'd1);
    check("err_mask2", 32'(br_mask_o), 32'b00111);

    // Build mask 01011, then assert reset asynchronously mid-cycle.
    drive(2'b01, BR_PR_CORRECT, 5'b00100);
    check("pre_tag0", 32'(br_tag_o[4:0]), 32'b01000);
    step();
    check("pre_mask", 32'(br_mask_o), 32'b01011);
    drive('0, BR_PR_NONE, '0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_mask", 32'(br_mask_o), 32'h0);
    check("arst_free", 32'(free_cnt_o), 32'd5);
    check("arst_full", 32'(full_o), 32'd0);
    check("arst_err",  32'(rslv_err_o), 32'd0);
    check("arst_gnt",  32'(br_gnt_o), 32'd0);
    check("arst_sq",   32'(br_squash_mask_o | br_clr_bit_o), 32'd0);
    step();
    check("arst_hold", 32'(br_mask_o), 32'h0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
